// File: rtl/mxint8_negate_arbiter_pkg.sv
// Shared MXINT8 block-format defaults used by the negate arbiter and its datapath.
package mxint8_negate_arbiter_pkg;
  localparam int MXINT8_BLOCK_SIZE_DEF    = 32;
  localparam int MXINT8_ELEMENT_WIDTH_DEF = 8;
  localparam int MXINT8_SCALE_WIDTH_DEF   = 8;
endpackage

// File: rtl/mxint8_negate.sv
// Result register for one MXINT8 block: optional per-element negation, scale passed through.
module mxint8_negate
  import mxint8_negate_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE           = MXINT8_BLOCK_SIZE_DEF,
  parameter int MXINT8_ELEMENT_WIDTH = MXINT8_ELEMENT_WIDTH_DEF,
  parameter int MXINT8_SCALE_WIDTH   = MXINT8_SCALE_WIDTH_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load,
  input  logic                            i_op,
  input  logic [MXINT8_SCALE_WIDTH-1:0]   i_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_elements [BLOCK_SIZE],
  output logic [MXINT8_SCALE_WIDTH-1:0]   o_scale,
  output logic [MXINT8_ELEMENT_WIDTH-1:0] o_elements [BLOCK_SIZE]
);
  logic [MXINT8_SCALE_WIDTH-1:0]   scale_q;
  logic [MXINT8_ELEMENT_WIDTH-1:0] el_d [BLOCK_SIZE];
  logic [MXINT8_ELEMENT_WIDTH-1:0] el_q [BLOCK_SIZE];

  // Modular negation: the most negative code maps onto itself, no saturation.
  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++)
      el_d[i] = i_op ? ('0 - i_elements[i]) : i_elements[i];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scale_q <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) el_q[i] <= '0;
    end else if (i_load) begin
      scale_q <= i_scale;
      for (int i = 0; i < BLOCK_SIZE; i++) el_q[i] <= el_d[i];
    end
  end

  assign o_scale    = scale_q;
  assign o_elements = el_q;
endmodule

// File: rtl/mxint8_negate_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry MXINT8 negate/pass-through stage.
module mxint8_negate_arbiter
  import mxint8_negate_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE           = MXINT8_BLOCK_SIZE_DEF,
  parameter int MXINT8_ELEMENT_WIDTH = MXINT8_ELEMENT_WIDTH_DEF,
  parameter int MXINT8_SCALE_WIDTH   = MXINT8_SCALE_WIDTH_DEF
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_req0_valid,
  output logic                            o_req0_ready,
  input  logic                            i_req0_op,
  input  logic [MXINT8_SCALE_WIDTH-1:0]   i_req0_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_req0_elements [BLOCK_SIZE],
  input  logic                            i_req1_valid,
  output logic                            o_req1_ready,
  input  logic                            i_req1_op,
  input  logic [MXINT8_SCALE_WIDTH-1:0]   i_req1_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_req1_elements [BLOCK_SIZE],
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [MXINT8_SCALE_WIDTH-1:0]   o_scale,
  output logic [MXINT8_ELEMENT_WIDTH-1:0] o_elements [BLOCK_SIZE],
  output logic                            o_id,
  output logic [15:0]                     o_blk_count
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q;
  logic        ptr_q;
  logic        id_q;
  logic [15:0] cnt_q;

  logic grant, slot_free, accept, deliver;
  logic sel_op;
  logic [MXINT8_SCALE_WIDTH-1:0]   sel_scale;
  logic [MXINT8_ELEMENT_WIDTH-1:0] sel_el [BLOCK_SIZE];

  // Grant depends only on valids and the pointer, never on payload.
  assign grant        = (i_req0_valid & i_req1_valid) ? ptr_q : i_req1_valid;
  assign slot_free    = (state_q == EMPTY) | i_ready;
  assign o_req0_ready = ~i_rst & slot_free & ~grant & i_req0_valid;
  assign o_req1_ready = ~i_rst & slot_free &  grant & i_req1_valid;
  assign accept       = o_req0_ready | o_req1_ready;
  assign deliver      = (state_q == FULL) & i_ready;

  always_comb begin
    sel_op    = grant ? i_req1_op    : i_req0_op;
    sel_scale = grant ? i_req1_scale : i_req0_scale;
    for (int i = 0; i < BLOCK_SIZE; i++)
      sel_el[i] = grant ? i_req1_elements[i] : i_req0_elements[i];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (deliver) cnt_q <= cnt_q + 16'd1;
      // A same-cycle accept refills the slot being drained, so no bubble.
      if (accept) begin
        state_q <= FULL;
        id_q    <= grant;
        ptr_q   <= ~grant;
      end else if (deliver) begin
        state_q <= EMPTY;
      end
    end
  end

  mxint8_negate #(
    .BLOCK_SIZE          (BLOCK_SIZE),
    .MXINT8_ELEMENT_WIDTH(MXINT8_ELEMENT_WIDTH),
    .MXINT8_SCALE_WIDTH  (MXINT8_SCALE_WIDTH)
  ) u_negate (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (accept),
    .i_op      (sel_op),
    .i_scale   (sel_scale),
    .i_elements(sel_el),
    .o_scale   (o_scale),
    .o_elements(o_elements)
  );

  assign o_valid     = (state_q == FULL);
  assign o_id        = id_q;
  assign o_blk_count = cnt_q;
endmodule

// File: tb/tb_mxint8_negate_arbiter.sv
// Directed + random bench for mxint8_negate_arbiter against a transaction-level reference model.
module tb_mxint8_negate_arbiter;
  localparam int BS = 32;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       v0, v1, op0, op1, rdy;
  logic [7:0] sc0, sc1;
  logic [7:0] el0 [BS];
  logic [7:0] el1 [BS];
  logic       r0, r1, o_valid, o_id;
  logic [7:0] o_scale;
  logic [7:0] o_el [BS];
  logic [15:0] o_blk_count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_full;
  bit          m_id;
  bit          m_ptr;
  logic [7:0]  m_scale;
  logic [7:0]  m_el [BS];
  logic [15:0] m_cnt;
  int          delivered;
  bit          g;

  logic [255:0] snap_el;
  logic [7:0]   snap_sc;
  logic         snap_id;
  logic [255:0] exp_pk;
  bit           id_seq [4];

  always #5 i_clk = ~i_clk;

  mxint8_negate_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0),
    .i_req0_scale(sc0), .i_req0_elements(el0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1),
    .i_req1_scale(sc1), .i_req1_elements(el1),
    .o_valid(o_valid), .i_ready(rdy), .o_scale(o_scale),
    .o_elements(o_el), .o_id(o_id), .o_blk_count(o_blk_count)
  );

  function automatic logic [255:0] pack(input logic [7:0] a [BS]);
    logic [255:0] p;
    for (int i = 0; i < BS; i++) p[i*8 +: 8] = a[i];
    return p;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    op0 = 1'($urandom_range(0, 1));
    op1 = 1'($urandom_range(0, 1));
    sc0 = 8'($urandom);
    sc1 = 8'($urandom);
    for (int i = 0; i < BS; i++) begin
      el0[i] = 8'($urandom);
      el1[i] = 8'($urandom);
    end
  endtask

  // Before the edge: check readies from the handshake rules, then advance the model.
  task automatic pre();
    bit free, e0, e1;
    #1;
    free = !m_full || rdy;
    g    = (v0 && v1) ? m_ptr : v1;
    e0   = !i_rst && free && v0 && !g;
    e1   = !i_rst && free && v1 && g;
    chk("req0_ready", r0, e0);
    chk("req1_ready", r1, e1);
    if (i_rst) begin
      m_full = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_scale = 0; delivered = 0;
      for (int i = 0; i < BS; i++) m_el[i] = 0;
    end else begin
      if (m_full && rdy) begin
        m_cnt = m_cnt + 16'd1;
        delivered++;
      end
      if (e0 || e1) begin
        m_full  = 1;
        m_id    = g;
        m_ptr   = !g;
        m_scale = g ? sc1 : sc0;
        for (int i = 0; i < BS; i++) begin
          if (g) m_el[i] = op1 ? 8'(0 - int'(el1[i])) : el1[i];
          else   m_el[i] = op0 ? 8'(0 - int'(el0[i])) : el0[i];
        end
      end else if (m_full && rdy) begin
        m_full = 0;
      end
    end
  endtask

  task automatic post();
    @(negedge i_clk);
    chk("o_valid", o_valid, m_full);
    chk("o_blk_count", o_blk_count, m_cnt);
    if (m_full) begin
      chk("o_id", o_id, m_id);
      chk("o_scale", o_scale, m_scale);
      chk("o_elements", pack(o_el), pack(m_el));
    end
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  initial begin
    i_rst = 1; v0 = 0; v1 = 0; rdy = 0;
    rand_data();
    m_full = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_scale = 0; delivered = 0;
    for (int i = 0; i < BS; i++) m_el[i] = 0;

    // reset state
    cyc(); cyc();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_cnt", o_blk_count, 16'h0);
    chk("rst_id", o_id, 1'b0);
    chk("rst_scale", o_scale, 8'h0);
    chk("rst_elements", pack(o_el), 256'h0);
    i_rst = 0;

    // req0 alone, negate 0x05 -> 0xFB
    v0 = 1; v1 = 0; rdy = 1; op0 = 1; sc0 = 8'h7F;
    for (int i = 0; i < BS; i++) el0[i] = 8'h05;
    cyc();
    chk("neg05_valid", o_valid, 1'b1);
    chk("neg05_scale", o_scale, 8'h7F);
    chk("neg05_id", o_id, 1'b0);
    chk("neg05_elements", pack(o_el), {32{8'hFB}});

    // req1 alone, negation boundaries
    v0 = 0; v1 = 1;
    rand_data();
    op1 = 1; el1[0] = 8'h80; el1[1] = 8'h00; el1[2] = 8'h7F; el1[3] = 8'hFF;
    cyc();
    chk("neg_bound_lo", pack(o_el) & 256'hFFFFFFFF, 256'h01810080);
    chk("neg_bound_id", o_id, 1'b1);

    // both valid, downstream always ready: alternate with no bubble
    v0 = 1; v1 = 1;
    id_seq[0] = 0; id_seq[1] = 1; id_seq[2] = 0; id_seq[3] = 1;
    for (int k = 0; k < 4; k++) begin
      rand_data();
      cyc();
      chk("rr_valid", o_valid, 1'b1);
      chk("rr_id", o_id, id_seq[k]);
    end

    // backpressure: result must hold and no request is accepted
    rdy = 0;
    snap_el = pack(o_el); snap_sc = o_scale; snap_id = o_id;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      pre();
      chk("stall_rdy", {r0, r1}, 2'b00);
      post();
      chk("stall_elements", pack(o_el), snap_el);
      chk("stall_scale", o_scale, snap_sc);
      chk("stall_id", o_id, snap_id);
      chk("stall_valid", o_valid, 1'b1);
    end
    rdy = 1;
    rand_data();
    pre();
    chk("release_accept", r0 | r1, 1'b1);
    post();

    // pass-through of 0x80
    v0 = 1; v1 = 0; op0 = 0;
    for (int i = 0; i < BS; i++) el0[i] = 8'h80;
    cyc();
    if (o_id == 1'b0) chk("pass80_elements", pack(o_el), {32{8'h80}});
    else chk("pass80_id", o_id, 1'b0);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      v0  = 1'($urandom_range(0, 1));
      v1  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      rand_data();
      cyc();
    end

    // reset while FULL
    v0 = 1; v1 = 1; rdy = 0;
    cyc();
    chk("pre_rst_full", o_valid, 1'b1);
    i_rst = 1;
    cyc();
    chk("rst_full_valid", o_valid, 1'b0);
    chk("rst_full_cnt", o_blk_count, 16'h0);
    i_rst = 0; rdy = 1;
    rand_data();
    cyc();
    chk("post_rst_grant", o_id, 1'b0);

    // counter wrap after 65536 deliveries
    for (int k = 0; k < 70000 && delivered < 65536; k++) begin
      sc0 = 8'(k); sc1 = 8'(k + 1); op0 = k[0]; op1 = k[1];
      cyc();
    end
    chk("wrap_deliveries", delivered, 65536);
    chk("wrap_cnt", o_blk_count, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
